// File: rtl/wb_cdb_arbiter_pkg.sv
// Shared types for the writeback/CDB arbiter: FU identifiers and the writeback packet.
package wb_cdb_arbiter_pkg;

   localparam int WB_N_FU = 3;

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_BR  = 2'd1,
      FU_LSU = 2'd2
   } fu_id_e;

   typedef struct packed {
      logic        rd_we;
      logic [5:0]  prd;
      logic [31:0] rd_val;
      logic [5:0]  rob_idx;
      fu_id_e      src_fu;
   } wb_packet_t;

endpackage

// File: rtl/wb_cdb_arbiter_rr.sv
// Round-robin arbiter: scans req upward from rr_ptr; owns the rotating pointer.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   input  logic [$clog2(N)-1:0] grant_idx,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] rr_ptr;

   always_comb begin
      int k;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= N) k = k - N;
         if (!any && req[k]) begin
            any     = 1'b1;
            gnt[k]  = 1'b1;
            gnt_idx = IW'(k);
         end
      end
   end

   // The pointer moves to one past the winner, so the winner becomes lowest priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (advance)
         rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback/CDB port arbiter: round-robin grant into a one-entry output register.
// Optional performance counters are built when WB_ARB_PERF_EN is defined.
module wb_cdb_arbiter
   import wb_cdb_arbiter_pkg::*;
#(
   parameter int N_FU  = WB_N_FU,
   parameter int CNT_W = 32
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic [N_FU-1:0]            fu_valid_i,
   input  wb_packet_t [N_FU-1:0]      fu_packet_i,
   output logic [N_FU-1:0]            fu_ready_o,
   output logic                       wb_valid_o,
   input  logic                       wb_ready_i,
   output wb_packet_t                 wb_packet_o
`ifdef WB_ARB_PERF_EN
   ,
   output logic [N_FU-1:0][CNT_W-1:0] grant_cnt_o,
   output logic [CNT_W-1:0]           stall_cnt_o
`endif
);

   localparam int IW = $clog2(N_FU);

   logic            load_en;
   logic            fire;
   logic            any;
   logic [N_FU-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   wb_packet_t      nxt_packet;

   // Reset also blocks acceptance so no FU sees a handshake while the block is held.
   assign load_en    = !reset_i && !flush_i && (!wb_valid_o || wb_ready_i);
   assign fu_ready_o = load_en ? gnt : '0;
   assign fire       = load_en && any;

   rr_arbiter #(.N(N_FU)) u_rr (
      .clk       (clk_i),
      .rst       (reset_i),
      .req       (fu_valid_i),
      .advance   (fire),
      .grant_idx (gnt_idx),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .any       (any)
   );

   always_comb begin
      nxt_packet        = fu_packet_i[gnt_idx];
      nxt_packet.src_fu = fu_id_e'(gnt_idx);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wb_valid_o  <= 1'b0;
         wb_packet_o <= '0;
      end else if (flush_i) begin
         wb_valid_o  <= 1'b0;
      end else if (fire) begin
         wb_valid_o  <= 1'b1;
         wb_packet_o <= nxt_packet;
      end else if (wb_ready_i) begin
         wb_valid_o  <= 1'b0;
      end
   end

`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         grant_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (fire)
            grant_cnt_o[gnt_idx] <= grant_cnt_o[gnt_idx] + 1'b1;
         if (|fu_valid_i && !load_en && !flush_i)
            stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end
`else
`endif

   a_ready_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
      $onehot0(fu_ready_o));

   a_hold_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (wb_valid_o && !wb_ready_i && !flush_i) |=> $stable(wb_packet_o));

   a_valid_known: assert property (@(posedge clk_i) disable iff (reset_i)
      !$isunknown(wb_valid_o));

endmodule
